// File: rtl/text_overlay_mixer.sv
// Text overlay mixer: aligns background, syncs and box flag with the renderer's
// text stream, then alpha-blends text over background with a per-frame fade.
module text_overlay_mixer #(
  parameter int TEXT_LAT  = 3,
  parameter int FADE_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [23:0] bg_pixel,
  input  logic [23:0] text_pixel,
  input  logic [10:0] box_x,
  input  logic [9:0]  box_y,
  input  logic [10:0] box_w,
  input  logic [9:0]  box_h,
  input  logic        show,
  output logic [23:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic [4:0]  alpha,
  output logic [1:0]  fade_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    HOLD     = 2'd2,
    FADE_OUT = 2'd3
  } fade_t;

  fade_t       state_r, state_nx;
  logic [4:0]  alpha_r, alpha_nx;
  logic        vsync_r;
  logic        tick_s;
  logic        in_box_s;
  logic [11:0] h12, x_lo, x_hi, v12, y_lo, y_hi;
  logic [5:0]  up_s, dn_s;

  // control bits per stage: {in_box, hsync, vsync, blank}
  logic [23:0] bg_pipe  [TEXT_LAT];
  logic [3:0]  ctl_pipe [TEXT_LAT];
  logic        box_d, hs_d, vs_d, bl_d, text_on_s;

  function automatic logic [7:0] blend(input logic [7:0] t, input logic [7:0] b,
                                       input logic [4:0] a);
    logic [12:0] pt, pb, sum;
    pt  = {5'd0, t} * {8'd0, a};
    pb  = {5'd0, b} * {8'd0, 5'd16 - a};
    sum = pt + pb;
    return sum[11:4];
  endfunction

  // Widen to 12 bits so box_x+box_w cannot wrap past the screen edge
  assign h12  = {1'b0, hcount};
  assign x_lo = {1'b0, box_x};
  assign x_hi = {1'b0, box_x} + {1'b0, box_w};
  assign v12  = {2'b00, vcount};
  assign y_lo = {2'b00, box_y};
  assign y_hi = {2'b00, box_y} + {2'b00, box_h};
  assign in_box_s = (h12 >= x_lo) && (h12 < x_hi) && (v12 >= y_lo) && (v12 < y_hi);

  assign tick_s = vsync && !vsync_r;
  assign box_d  = ctl_pipe[TEXT_LAT-1][3];
  assign hs_d   = ctl_pipe[TEXT_LAT-1][2];
  assign vs_d   = ctl_pipe[TEXT_LAT-1][1];
  assign bl_d   = ctl_pipe[TEXT_LAT-1][0];
  assign text_on_s = box_d && (text_pixel != 24'd0) && !bl_d;

  // Delay lines matching the renderer latency
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TEXT_LAT; i++) begin
        bg_pipe[i]  <= 24'd0;
        ctl_pipe[i] <= 4'd0;
      end
      vsync_r <= 1'b0;
    end else begin
      for (int i = TEXT_LAT - 1; i > 0; i--) begin
        bg_pipe[i]  <= bg_pipe[i-1];
        ctl_pipe[i] <= ctl_pipe[i-1];
      end
      bg_pipe[0]  <= bg_pixel;
      ctl_pipe[0] <= {in_box_s, hsync, vsync, blank};
      vsync_r     <= vsync;
    end
  end

  // Final mix stage and delayed syncs
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out <= 24'd0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
    end else begin
      hsync_out <= hs_d;
      vsync_out <= vs_d;
      blank_out <= bl_d;
      if (bl_d) begin
        pixel_out <= 24'd0;
      end else if (text_on_s) begin
        pixel_out <= {blend(text_pixel[23:16], bg_pipe[TEXT_LAT-1][23:16], alpha_r),
                      blend(text_pixel[15:8],  bg_pipe[TEXT_LAT-1][15:8],  alpha_r),
                      blend(text_pixel[7:0],   bg_pipe[TEXT_LAT-1][7:0],   alpha_r)};
      end else begin
        pixel_out <= bg_pipe[TEXT_LAT-1];
      end
    end
  end

  // Fade state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      alpha_r <= 5'd0;
    end else begin
      state_r <= state_nx;
      alpha_r <= alpha_nx;
    end
  end

  assign up_s = {1'b0, alpha_r} + 6'(FADE_STEP);
  assign dn_s = {1'b0, alpha_r} - 6'(FADE_STEP);

  // Fade next-state: only frame ticks move the state or alpha
  always_comb begin
    state_nx = state_r;
    alpha_nx = alpha_r;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (show) state_nx = FADE_IN;
          else      state_nx = IDLE;
        end
        FADE_IN: begin
          if (!show) begin
            state_nx = FADE_OUT;
          end else if (up_s >= 6'd16) begin
            alpha_nx = 5'd16;
            state_nx = HOLD;
          end else begin
            alpha_nx = up_s[4:0];
          end
        end
        HOLD: begin
          alpha_nx = 5'd16;
          if (!show) state_nx = FADE_OUT;
          else       state_nx = HOLD;
        end
        FADE_OUT: begin
          if (show) begin
            state_nx = FADE_IN;
          end else if ({1'b0, alpha_r} <= 6'(FADE_STEP)) begin
            alpha_nx = 5'd0;
            state_nx = IDLE;
          end else begin
            alpha_nx = dn_s[4:0];
          end
        end
        default: begin
          state_nx = IDLE;
          alpha_nx = 5'd0;
        end
      endcase
    end else begin
      state_nx = state_r;
      alpha_nx = alpha_r;
    end
  end

  assign alpha      = alpha_r;
  assign fade_state = state_r;

endmodule

// File: tb/tb_text_overlay_mixer.sv
// Self-checking bench for text_overlay_mixer: scoreboard on the pixel stream,
// inline checks on the fade FSM across frame ticks.
module tb_text_overlay_mixer;

  localparam int TL = 3;
  localparam int FS = 4;
  localparam int BX = 100;
  localparam int BY = 50;
  localparam int BW = 20;
  localparam int BH = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b0, vsync = 1'b0, blank = 1'b1;
  logic [23:0] bg_pixel = '0, text_pixel = '0;
  logic [10:0] box_x = 11'(BX), box_w = 11'(BW);
  logic [9:0]  box_y = 10'(BY), box_h = 10'(BH);
  logic        show = 1'b0;
  logic [23:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out;
  logic [4:0]  alpha;
  logic [1:0]  fade_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] h; logic [9:0] v; logic [23:0] bg; logic [23:0] txt;
    logic bl; logic hs; logic vs;
  } stim_t;
  typedef struct { logic [23:0] pix; logic hs; logic vs; logic bl; } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  text_overlay_mixer #(.TEXT_LAT(TL), .FADE_STEP(FS)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .bg_pixel(bg_pixel),
    .text_pixel(text_pixel), .box_x(box_x), .box_y(box_y), .box_w(box_w),
    .box_h(box_h), .show(show), .pixel_out(pixel_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .blank_out(blank_out), .alpha(alpha),
    .fade_state(fade_state)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(stim_t s, int a);
    exp_t e;
    bit   inb, on;
    int   t, b, r;
    inb = (int'(s.h) >= BX) && (int'(s.h) < BX + BW) &&
          (int'(s.v) >= BY) && (int'(s.v) < BY + BH);
    on  = inb && (s.txt != 24'd0) && !s.bl;
    e.hs = s.hs; e.vs = s.vs; e.bl = s.bl;
    if (s.bl) e.pix = 24'd0;
    else if (!on) e.pix = s.bg;
    else begin
      for (int c = 0; c < 3; c++) begin
        t = int'((s.txt >> (8 * c)) & 24'hFF);
        b = int'((s.bg >> (8 * c)) & 24'hFF);
        r = (t * a + b * (16 - a)) / 16;
        e.pix[8*c +: 8] = 8'(r);
      end
    end
    return e;
  endfunction

  task automatic add(input int h, input int v, input logic [23:0] bg,
                     input logic [23:0] txt, input logic bl, input logic hs,
                     input logic vs);
    stim_t s;
    s.h = 11'(h); s.v = 10'(v); s.bg = bg; s.txt = txt;
    s.bl = bl; s.hs = hs; s.vs = vs;
    stim_q.push_back(s);
  endtask

  // Drives queued pixels (text lagging by TL), scoring outputs TL+1 cycles later
  task automatic run_stream(input string name, input int a);
    int    n;
    exp_t  e;
    stim_t s;
    n = stim_q.size();
    for (int c = 0; c < n + TL + 1; c++) begin
      @(negedge clk);
      if (c >= TL + 1) begin
        e = exp_q.pop_front();
        checks++;
        if (pixel_out !== e.pix || hsync_out !== e.hs || vsync_out !== e.vs ||
            blank_out !== e.bl) begin
          errors++;
          $display("FAIL %s[%0d]: got pix=%h hs=%b vs=%b bl=%b, want pix=%h hs=%b vs=%b bl=%b",
                   name, c - TL - 1, pixel_out, hsync_out, vsync_out, blank_out,
                   e.pix, e.hs, e.vs, e.bl);
        end
      end
      if (c >= TL && c - TL < n) text_pixel = stim_q[c-TL].txt;
      else text_pixel = 24'd0;
      if (c < n) begin
        s = stim_q[c];
        hcount = s.h; vcount = s.v; bg_pixel = s.bg;
        blank = s.bl; hsync = s.hs; vsync = s.vs;
        exp_q.push_back(model(s, a));
      end else begin
        hcount = '0; vcount = '0; bg_pixel = '0;
        blank = 1'b1; hsync = 1'b0; vsync = 1'b0;
      end
    end
    stim_q.delete();
  endtask

  task automatic frame_tick();
    @(negedge clk);
    vsync = 1'b1; blank = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic tick_expect(input string name, input int st, input int a);
    frame_tick();
    checks++;
    if (fade_state !== 2'(st) || alpha !== 5'(a)) begin
      errors++;
      $display("FAIL %s: got state=%0d alpha=%0d, want state=%0d alpha=%0d",
               name, fade_state, alpha, st, a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pixel_out !== 24'd0 || hsync_out !== 1'b0 || vsync_out !== 1'b0 ||
        blank_out !== 1'b0 || alpha !== 5'd0 || fade_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: got pix=%h hs=%b vs=%b bl=%b alpha=%0d state=%0d, want all 0",
               pixel_out, hsync_out, vsync_out, blank_out, alpha, fade_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    show = 1'b0;
    add(105, 55, 24'h123456, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(106, 55, 24'h654321, 24'h00FF00, 1'b0, 1'b1, 1'b0);
    add(10,  5,  24'hA5A5A5, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
    run_stream("passthrough", 0);
    checks++;
    if (alpha !== 5'd0) begin
      errors++;
      $display("FAIL passthrough_alpha: got %0d want 0", alpha);
    end
  endtask

  task automatic test_fade_in();
    show = 1'b1;
    tick_expect("fade_in_t1", 1, 0);
    tick_expect("fade_in_t2", 1, 4);
    tick_expect("fade_in_t3", 1, 8);
    add(105, 55, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(106, 55, 24'h0000FF, 24'h000000, 1'b0, 1'b0, 1'b0);
    add(107, 56, 24'h204060, 24'h80C0F0, 1'b0, 1'b0, 1'b0);
    run_stream("mix_alpha8", 8);
    tick_expect("fade_in_t4", 1, 12);
    tick_expect("fade_in_t5", 2, 16);
    add(105, 55, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    run_stream("mix_alpha16", 16);
  endtask

  task automatic test_box_edges();
    add(BX - 1,  55, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(BX,      55, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(BX+BW-1, 55, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(BX+BW,   55, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(105, BY - 1, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(105, BY,     24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(105, BY+BH-1, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(105, BY+BH,  24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    run_stream("box_edges", 16);
  endtask

  task automatic test_fade_out();
    show = 1'b0;
    tick_expect("fade_out_enter", 3, 16);
    tick_expect("fade_out_12", 3, 12);
    tick_expect("fade_out_8", 3, 8);
    show = 1'b1;
    tick_expect("refade_in_8", 1, 8);
    tick_expect("refade_in_12", 1, 12);
    show = 1'b0;
    tick_expect("fade_out2_enter", 3, 12);
    tick_expect("fade_out2_8", 3, 8);
    tick_expect("fade_out2_4", 3, 4);
    tick_expect("fade_out2_idle", 0, 0);
    show = 1'b1;
    repeat (5) @(negedge clk);
    show = 1'b0;
    tick_expect("show_glitch_ignored", 0, 0);
  endtask

  task automatic test_blank_syncs();
    show = 1'b1;
    tick_expect("hold_t1", 1, 0);
    tick_expect("hold_t2", 1, 4);
    tick_expect("hold_t3", 1, 8);
    tick_expect("hold_t4", 1, 12);
    tick_expect("hold_t5", 2, 16);
    add(105, 55, 24'h0000FF, 24'hFF0000, 1'b1, 1'b1, 1'b0);
    add(106, 55, 24'h0000FF, 24'hFF0000, 1'b1, 1'b0, 1'b1);
    add(107, 55, 24'h0000FF, 24'hFF0000, 1'b1, 1'b1, 1'b1);
    add(108, 55, 24'h0000FF, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(109, 55, 24'h0000FF, 24'hFF0000, 1'b1, 1'b1, 1'b0);
    run_stream("blank_syncs", 16);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    hcount = 11'd5; vcount = 10'd5; bg_pixel = 24'hABCDEF; blank = 1'b0;
    hsync = 1'b0; vsync = 1'b0; text_pixel = 24'd0;
    repeat (TL + 2) @(negedge clk);
    checks++;
    if (pixel_out !== 24'hABCDEF) begin
      errors++;
      $display("FAIL pre_reset_pix: got %h want abcdef", pixel_out);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pixel_out !== 24'd0 || alpha !== 5'd0 || fade_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: got pix=%h alpha=%0d state=%0d, want 0/0/0",
               pixel_out, alpha, fade_state);
    end
    reset = 1'b0;
    for (int i = 0; i < TL; i++) begin
      @(negedge clk);
      checks++;
      if (pixel_out !== 24'd0) begin
        errors++;
        $display("FAIL flush[%0d]: got %h want 000000", i, pixel_out);
      end
    end
    @(negedge clk);
    checks++;
    if (pixel_out !== 24'hABCDEF) begin
      errors++;
      $display("FAIL post_flush_pix: got %h want abcdef", pixel_out);
    end
    show = 1'b1;
    tick_expect("recover_t1", 1, 0);
    tick_expect("recover_t2", 1, 4);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fade_in();
    test_box_edges();
    test_fade_out();
    test_blank_syncs();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
